fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch stage: owns the program counter, drives instruction-memory address,
//   computes PC+4 and registers {valid, instr, PC, PC_plus4} into the IF/ID pipeline register.
//   ifid_PC_plus4 is the value branch_link later writes to X30 on BL. Accepts stall from
//   hazard unit and redirect (taken B/B.cond/CBZ/BL/BR) from branch resolution.
// PARAMETERS
//   RESET_PC   64'h0          PC value loaded on reset (first fetch address)
//   NOP_INSTR  32'hD503201F   ARM64 NOP encoding inserted as bubble
// PORTS
//   clk               in   1   clock, all state updates on rising edge
//   reset             in   1   synchronous, active-high reset
//   stall             in   1   hold PC and IF/ID (load-use hazard)
//   redirect          in   1   taken branch: load new PC, flush IF/ID
//   redirect_use_reg  in   1   1 = BR (target from register), 0 = PC-relative
//   redirect_base_pc  in   64  PC of the branch instruction
//   redirect_offset   in   64  sign-extended word offset (imm26/imm19 already extended)
//   redirect_reg      in   64  register target for BR
//   imem_addr         out  64  fetch address = current PC (combinational from PC reg)
//   imem_instr        in   32  instruction at imem_addr, asynchronous read, same cycle
//   ifid_valid        out  1   IF/ID holds a real instruction
//   ifid_instr        out  32  IF/ID instruction
//   ifid_PC           out  64  PC of ifid_instr
//   ifid_PC_plus4     out  64  ifid_PC + 4
// BEHAVIOUR
//   - Reset (clk edge with reset=1): pc<=RESET_PC; ifid_valid<=0; ifid_instr<=NOP_INSTR;
//     ifid_PC<=0; ifid_PC_plus4<=0. Reset overrides stall and redirect; mid-stream reset
//     discards all in-flight state. First fetch at RESET_PC in cycle after reset drops.
//   - Priority per edge: reset > redirect > stall > sequential.
//   - Sequential: pc<=pc+4; IF/ID<={1, imem_instr, pc, pc+4}. Latency: instruction at
//     address A appears on ifid_* exactly one edge after imem_addr==A.
//   - Stall (redirect=0): pc and all ifid_* hold their values; imem_addr stable.
//   - Redirect: pc<=target; IF/ID<=bubble {0, NOP_INSTR, 0, 0}, regardless of stall.
//     target = redirect_use_reg ? redirect_reg : redirect_base_pc + (redirect_offset<<2);
//     both forms then have bits[1:0] forced to 2'b00. Instruction fetched this cycle is dropped.
//   - Arithmetic: all 64-bit, modulo 2^64; pc=64'hFFFF_FFFF_FFFF_FFFC wraps to 0,
//     ifid_PC_plus4 = 0 for that instruction. Negative offsets wrap identically.
//   - Back-to-back redirects: each edge takes newest target; IF/ID stays bubble.
//   - Redirect the cycle after stall release: normal redirect, no extra bubble.
//   - No state machine beyond PC/IF-ID registers; no internal counters.
// STRUCTURE
//   - Shared package cpu_pkg: NOP_INSTR, RESET_PC defaults, XLEN=64, INSTR_W=32,
//     ifid_t struct {valid, instr, pc, pc_plus4}.
//   - Sub-module pc_next_sel: combinational adder (pc+4, base+offset<<2), target mux,
//     alignment mask, priority select of next PC. fetch_stage holds registers only.
// TESTING
//   1 reset 3 cycles, RESET_PC=0 -> ifid_valid=0, ifid_instr=D503201F, imem_addr=0;
//     after release, 3 edges -> imem_addr=0xC, ifid_PC=8, ifid_PC_plus4=0xC, valid=1.
//   2 stall 2 cycles at pc=0x10 -> imem_addr=0x10 and ifid_* unchanged both cycles;
//     release -> ifid_PC=0x10 next edge.
//   3 redirect base=0x40 offset=-4 (64'hFFFF_FFFF_FFFF_FFFC) -> pc=0x30, next ifid_valid=0,
//     ifid_instr=NOP; following edge ifid_PC=0x30.
//   4 redirect_use_reg=1 reg=0x1003 with stall=1 -> pc=0x1000, IF/ID bubble (redirect wins).
//   5 pc=FFFF_FFFF_FFFF_FFFC sequential -> imem_addr=0, ifid_PC_plus4=0.
//   6 reset asserted same edge as redirect to 0x200 -> pc=RESET_PC, ifid_valid=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the fetch stage.
package cpu_pkg;

  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'hD503201F;
  localparam logic [XLEN-1:0]    RESET_PC_DEFAULT  = '0;

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [INSTR_W-1:0] nop);
    ifid_t b;
    b.valid    = 1'b0;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    return b;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC computation: sequential increment, branch target formation and
// priority selection between reset, redirect, stall and fall-through.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            reset_i,
  input  logic            redirect_i,
  input  logic            stall_i,
  input  logic            use_reg_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] base_pc_i,
  input  logic [XLEN-1:0] offset_i,
  input  logic [XLEN-1:0] reg_target_i,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic [XLEN-1:0] pc_next_o
);

  logic [XLEN-1:0] relTarget;
  logic [XLEN-1:0] rawTarget;
  logic [XLEN-1:0] alignedTarget;

  // Word-aligned targets only; both branch forms are masked the same way.
  always_comb begin
    relTarget     = base_pc_i + (offset_i << 2);
    rawTarget     = use_reg_i ? reg_target_i : relTarget;
    alignedTarget = {rawTarget[XLEN-1:2], 2'b00};
  end

  assign pc_plus4_o = pc_i + 64'd4;

  always_comb begin
    pc_next_o = pc_plus4_o;
    if (reset_i)         pc_next_o = RESET_PC;
    else if (redirect_i) pc_next_o = alignedTarget;
    else if (stall_i)    pc_next_o = pc_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register and IF/ID pipeline register, with
// stall hold and redirect flush.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic               redirect_use_reg,
  input  logic [XLEN-1:0]    redirect_base_pc,
  input  logic [XLEN-1:0]    redirect_offset,
  input  logic [XLEN-1:0]    redirect_reg,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [XLEN-1:0]    ifid_PC,
  output logic [XLEN-1:0]    ifid_PC_plus4
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pcPlus4;
  ifid_t           ifid_q, ifid_d;

  pc_next_sel #(
    .RESET_PC(RESET_PC)
  ) u_pc_next_sel (
    .reset_i     (reset),
    .redirect_i  (redirect),
    .stall_i     (stall),
    .use_reg_i   (redirect_use_reg),
    .pc_i        (pc_q),
    .base_pc_i   (redirect_base_pc),
    .offset_i    (redirect_offset),
    .reg_target_i(redirect_reg),
    .pc_plus4_o  (pcPlus4),
    .pc_next_o   (pc_d)
  );

  // A redirect squashes whatever was fetched this cycle, even under stall.
  always_comb begin
    ifid_d = ifid_q;
    if (reset || redirect) begin
      ifid_d = ifid_bubble(NOP_INSTR);
    end else if (!stall) begin
      ifid_d.valid    = 1'b1;
      ifid_d.instr    = imem_instr;
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus4 = pcPlus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      ifid_q <= ifid_bubble(NOP_INSTR);
    end else begin
      pc_q   <= pc_d;
      ifid_q <= ifid_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_valid    = ifid_q.valid;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_PC       = ifid_q.pc;
  assign ifid_PC_plus4 = ifid_q.pc_plus4;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by random
// control/redirect traffic checked against a behavioural fetch model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'hD503201F;

  typedef struct {
    logic [63:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [63:0] pc;
    logic [63:0] pc4;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic        redirect_use_reg = 1'b0;
  logic [63:0] redirect_base_pc = '0;
  logic [63:0] redirect_offset = '0;
  logic [63:0] redirect_reg = '0;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [63:0] ifid_PC;
  logic [63:0] ifid_PC_plus4;

  int checks = 0;
  int failures = 0;
  exp_t expQ[$];

  // Model state: architectural PC and the IF/ID contents as described by the fetch rules.
  logic [63:0] mPc = '0;
  logic        mValid = 1'b0;
  logic [31:0] mInstr = NOP;
  logic [63:0] mIfPc = '0;
  logic [63:0] mIfPc4 = '0;

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_use_reg(redirect_use_reg),
    .redirect_base_pc(redirect_base_pc),
    .redirect_offset (redirect_offset),
    .redirect_reg    (redirect_reg),
    .imem_addr       (imem_addr),
    .imem_instr      (imem_instr),
    .ifid_valid      (ifid_valid),
    .ifid_instr      (ifid_instr),
    .ifid_PC         (ifid_PC),
    .ifid_PC_plus4   (ifid_PC_plus4)
  );

  always #5 clk = ~clk;

  // Instruction memory contents are a fixed scrambling of the address.
  function automatic logic [31:0] memWord(input logic [63:0] a);
    return (a[33:2] * 32'h9E3779B1) ^ a[63:32] ^ 32'h13579BDF;
  endfunction

  assign imem_instr = memWord(imem_addr);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of controls, advances the model and queues the expected post-edge view.
  task automatic applyStimulus(input logic rst, input logic st, input logic rd, input logic ur,
                               input logic [63:0] b, input logic [63:0] o, input logic [63:0] r);
    exp_t e;
    logic [63:0] tgt;
    @(negedge clk);
    reset = rst; stall = st; redirect = rd; redirect_use_reg = ur;
    redirect_base_pc = b; redirect_offset = o; redirect_reg = r;
    tgt = ur ? r : b + o * 64'd4;
    tgt = tgt & ~64'd3;
    if (rst || rd) begin
      mPc = rst ? 64'h0 : tgt;
      mValid = 1'b0; mInstr = NOP; mIfPc = '0; mIfPc4 = '0;
    end else if (!st) begin
      mValid = 1'b1; mInstr = memWord(mPc); mIfPc = mPc; mIfPc4 = mPc + 64'd4;
      mPc = mPc + 64'd4;
    end
    e.addr = mPc; e.valid = mValid; e.instr = mInstr; e.pc = mIfPc; e.pc4 = mIfPc4;
    expQ.push_back(e);
    @(posedge clk);
  endtask

  task automatic seqCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, '0, '0);
  endtask

  // Monitor: compares every queued expectation just after the edge it belongs to.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("imem_addr", imem_addr, e.addr);
        checkOutput("ifid_valid", {63'd0, ifid_valid}, {63'd0, e.valid});
        checkOutput("ifid_instr", {32'd0, ifid_instr}, {32'd0, e.instr});
        checkOutput("ifid_PC", ifid_PC, e.pc);
        checkOutput("ifid_PC_plus4", ifid_PC_plus4, e.pc4);
      end
    end
  end

  initial begin
    #400000;
    failures++;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] off;
    // Reset for three cycles, then three sequential fetches.
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0, '0, '0, '0);
    #2;
    checkOutput("reset_instr", {32'd0, ifid_instr}, {32'd0, NOP});
    seqCycles(3);
    #2;
    checkOutput("t1_imem_addr", imem_addr, 64'hC);
    checkOutput("t1_ifid_PC", ifid_PC, 64'h8);
    checkOutput("t1_ifid_PC_plus4", ifid_PC_plus4, 64'hC);

    // Stall two cycles at pc=0x10, then release.
    seqCycles(1);
    applyStimulus(0, 1, 0, 0, '0, '0, '0);
    applyStimulus(0, 1, 0, 0, '0, '0, '0);
    #2;
    checkOutput("t2_stall_addr", imem_addr, 64'h10);
    seqCycles(1);
    #2;
    checkOutput("t2_release_PC", ifid_PC, 64'h10);

    // PC-relative redirect with a negative offset.
    applyStimulus(0, 0, 1, 0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFF, '0);
    #2;
    checkOutput("t3_target", imem_addr, 64'h3C);
    applyStimulus(0, 0, 1, 0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFC, '0);
    #2;
    checkOutput("t3_target2", imem_addr, 64'h30);
    seqCycles(1);
    #2;
    checkOutput("t3_ifid_PC", ifid_PC, 64'h30);

    // Register redirect under stall: redirect wins and the target is aligned.
    applyStimulus(0, 1, 1, 1, '0, '0, 64'h1003);
    #2;
    checkOutput("t4_target", imem_addr, 64'h1000);

    // Wrap of the PC at the top of the address space.
    applyStimulus(0, 0, 1, 1, '0, '0, 64'hFFFF_FFFF_FFFF_FFFC);
    seqCycles(1);
    #2;
    checkOutput("t5_wrap_addr", imem_addr, 64'h0);
    checkOutput("t5_wrap_pc4", ifid_PC_plus4, 64'h0);

    // Reset on the same edge as a redirect.
    applyStimulus(1, 0, 1, 0, 64'h200, '0, '0);
    #2;
    checkOutput("t6_reset_addr", imem_addr, 64'h0);
    seqCycles(2);

    // Random traffic, including redirects right after stall release and back-to-back redirects.
    for (int i = 0; i < 400; i++) begin
      off = ($urandom_range(0, 1) == 1) ? {{48{1'b1}}, 16'($urandom)} : {48'd0, 16'($urandom)};
      if ($urandom_range(0, 7) == 0) off = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1,
                    {$urandom, $urandom}, off, {$urandom, $urandom});
    end
    applyStimulus(0, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
